// File: rtl/tnn_frame_sched.sv
// tnn_frame_sched: admits whole images into the TNN under an in-flight limit,
// frames result beats with a last marker and flags protocol faults.
module tnn_frame_sched #(
    parameter int PIX_PER_IMG  = 1024,
    parameter int RES_PER_IMG  = 3,
    parameter int MAX_INFLIGHT = 2,
    parameter int TIMEOUT_CYC  = 1048576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_err,
    input  logic        s_pix_valid,
    output logic        s_pix_ready,
    input  logic [63:0] s_pix_data,
    output logic        tnn_in_valid,
    output logic [63:0] tnn_in_data,
    input  logic        tnn_out_valid,
    input  logic [63:0] tnn_out_data,
    output logic        m_res_valid,
    output logic [63:0] m_res_data,
    output logic        m_res_last,
    input  logic        m_res_ready,
    output logic [2:0]  inflight,
    output logic [31:0] img_in_count,
    output logic [31:0] img_out_count,
    output logic        busy,
    output logic        err_unexpected,
    output logic        err_overflow,
    output logic        err_timeout
);
    localparam int PW = $clog2(PIX_PER_IMG + 1);
    localparam int RW = $clog2(RES_PER_IMG + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_nx;

    logic [PW-1:0] pix_cnt;
    logic [RW-1:0] res_cnt;
    logic [WW-1:0] wd;
    logic acc, pix_last, res_hit, res_last, wd_hit;

    always_comb begin
        s_pix_ready = state == STREAM;
        acc = s_pix_valid & s_pix_ready;
        pix_last = acc && pix_cnt == PW'(PIX_PER_IMG - 1);
        state_nx = state == IDLE ? ((enable && inflight < 3'(MAX_INFLIGHT)) ? STREAM : IDLE)
                                 : (pix_last ? IDLE : STREAM);
        res_hit = tnn_out_valid && inflight != 3'd0;
        res_last = res_hit && res_cnt == RW'(RES_PER_IMG - 1);
        wd_hit = inflight != 3'd0 && !tnn_out_valid && wd == WW'(TIMEOUT_CYC - 1);
        busy = state == STREAM || inflight != 3'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            pix_cnt        <= '0;
            res_cnt        <= '0;
            wd             <= '0;
            tnn_in_valid   <= 1'b0;
            tnn_in_data    <= '0;
            m_res_valid    <= 1'b0;
            m_res_data     <= '0;
            m_res_last     <= 1'b0;
            inflight       <= '0;
            img_in_count   <= '0;
            img_out_count  <= '0;
            err_unexpected <= 1'b0;
            err_overflow   <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            state        <= state_nx;
            pix_cnt      <= pix_last ? '0 : pix_cnt + PW'(acc);
            tnn_in_valid <= acc;
            if (acc) tnn_in_data <= s_pix_data;
            m_res_valid  <= res_hit;
            m_res_last   <= res_last;
            if (res_hit) m_res_data <= tnn_out_data;
            res_cnt       <= res_last ? '0 : res_cnt + RW'(res_hit);
            inflight      <= inflight + 3'(pix_last) - 3'(res_last);
            img_in_count  <= img_in_count + 32'(pix_last);
            img_out_count <= img_out_count + 32'(res_last);
            // watchdog saturates at its terminal value until activity or drain
            wd <= (inflight == 3'd0 || tnn_out_valid) ? '0 : (wd == WW'(TIMEOUT_CYC - 1) ? wd : wd + 1'b1);
            err_unexpected <= (err_unexpected & ~clear_err) | (tnn_out_valid && inflight == 3'd0);
            err_overflow   <= (err_overflow & ~clear_err) | (m_res_valid & ~m_res_ready);
            err_timeout    <= (err_timeout & ~clear_err) | wd_hit;
        end
    end
endmodule
